rf_level_ctrl: RTL and testbench

- Level-stack controller: the initiator side of the banked register file's `level` input.
- Tracks interrupt nesting and holds a LIFO of preempted levels.
- Selects the active bank on interrupt entry, exit and tail-chain.
- Raises a one-cycle `stall` on every bank switch so the core suppresses register-file writes during the change.

---
 rtl/rf_stack_pkg.sv | 19 +
 rtl/level_lifo.sv | 57 +++++
 rtl/rf_level_ctrl.sv | 132 +++++++++++++
 tb/tb_rf_level_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rf_stack_pkg.sv
// Shared types for the banked register-file level stack.
//   NumLevelsDefault : default number of register banks / priority levels
//   level_t          : bank index
//   depth_t          : count of stacked (preempted) levels
//   state_t          : controller FSM states
package rf_stack_pkg;

  localparam int NumLevelsDefault   = 8;
  localparam int IndexLevelsDefault = $clog2(NumLevelsDefault);

  typedef logic [IndexLevelsDefault-1:0] level_t;
  typedef logic [IndexLevelsDefault-1:0] depth_t;

  typedef enum logic {
    IDLE   = 1'b0,
    SWITCH = 1'b1
  } state_t;

endpackage

// File: rtl/level_lifo.sv
// LIFO of preempted levels.
//   clk       : system clock, rising edge
//   reset     : asynchronous active-low reset of the stack pointer
//   push      : store pushLevel on top (ignored while full)
//   pop       : discard the top entry (ignored while empty)
//   pushLevel : level to store
//   top       : most recently pushed level (undefined while empty)
//   depth     : number of stored entries, 0 .. NumLevels-1
//   empty     : depth == 0
//   full      : depth == NumLevels-1
module level_lifo
  import rf_stack_pkg::*;
#(
  parameter  int NumLevels   = NumLevelsDefault,
  localparam int IndexLevels = $clog2(NumLevels)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [IndexLevels-1:0] pushLevel,
  output logic [IndexLevels-1:0] top,
  output logic [IndexLevels-1:0] depth,
  output logic                   empty,
  output logic                   full
);

  localparam logic [IndexLevels-1:0] One     = IndexLevels'(1);
  localparam logic [IndexLevels-1:0] MaxDepth = IndexLevels'(NumLevels - 1);

  // Storage carries no reset: only entries below depth are ever read.
  logic [IndexLevels-1:0] mem [NumLevels];
  logic [IndexLevels-1:0] depthQ;

  assign empty = (depthQ == '0);
  assign full  = (depthQ == MaxDepth);
  assign depth = depthQ;
  assign top   = mem[depthQ - One];

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[depthQ] <= pushLevel;
    end
  end

  // Pointer saturates at both ends so depth never wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      depthQ <= '0;
    end else if (push && !full) begin
      depthQ <= depthQ + One;
    end else if (pop && !empty) begin
      depthQ <= depthQ - One;
    end
  end

endmodule

// File: rtl/rf_level_ctrl.sv
// Level-stack controller driving the banked register file's level input.
// Tracks interrupt nesting, keeps preempted levels on a LIFO and selects
// the active bank on entry, exit and tail-chain. Every bank switch spends
// one SWITCH cycle with stall high so the core holds writes.
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset
//   entryReq   : interrupt entry request, held until entryAck
//   entryLevel : requested level, stable while entryReq
//   entryAck   : one-cycle pulse, entry or tail-chain accepted
//   exitReq    : one-cycle pulse, return from handler
//   exitAck    : one-cycle pulse, exit (or tail-chain) performed
//   level      : active bank
//   depth      : number of stacked levels
//   empty/full : combinational decode of depth
//   stall      : bank switch in progress
//   error      : one-cycle pulse on exit while empty or push while full
module rf_level_ctrl
  import rf_stack_pkg::*;
#(
  parameter  int NumLevels   = NumLevelsDefault,
  localparam int IndexLevels = $clog2(NumLevels),
  localparam int DepthWidth  = $clog2(NumLevels)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   entryReq,
  input  logic [IndexLevels-1:0] entryLevel,
  output logic                   entryAck,
  input  logic                   exitReq,
  output logic                   exitAck,
  output logic [IndexLevels-1:0] level,
  output logic [DepthWidth-1:0]  depth,
  output logic                   empty,
  output logic                   full,
  output logic                   stall,
  output logic                   error
);

  state_t                 state, stateNext;
  logic [IndexLevels-1:0] levelQ, levelNext;
  logic                   entryAckNext, exitAckNext, stallNext, errorNext;
  logic                   push, pop;
  logic [IndexLevels-1:0] top;
  logic                   entryQualifies, tailChain;

  level_lifo #(.NumLevels(NumLevels)) uLifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .pushLevel (levelQ),
    .top       (top),
    .depth     (depth),
    .empty     (empty),
    .full      (full)
  );

  // Unsigned compares; a tail-chain needs a stacked level to return to,
  // so an exit while empty is an error and the entry is handled normally.
  assign entryQualifies = entryReq && (entryLevel > levelQ);
  assign tailChain      = exitReq && entryReq && !empty && (entryLevel > top);

  always_comb begin
    stateNext    = state;
    levelNext    = levelQ;
    push         = 1'b0;
    pop          = 1'b0;
    entryAckNext = 1'b0;
    exitAckNext  = 1'b0;
    stallNext    = 1'b0;
    errorNext    = 1'b0;
    unique case (state)
      IDLE: begin
        if (tailChain) begin
          levelNext    = entryLevel;
          entryAckNext = 1'b1;
          exitAckNext  = 1'b1;
          stallNext    = 1'b1;
          stateNext    = SWITCH;
        end else if (exitReq && !empty) begin
          // A pending entry that cannot tail-chain waits; exit wins.
          pop         = 1'b1;
          levelNext   = top;
          exitAckNext = 1'b1;
          stallNext   = 1'b1;
          stateNext   = SWITCH;
        end else begin
          if (exitReq) begin
            errorNext = 1'b1;
          end
          if (entryQualifies) begin
            if (full) begin
              errorNext = 1'b1;
            end else begin
              push         = 1'b1;
              levelNext    = entryLevel;
              entryAckNext = 1'b1;
              stallNext    = 1'b1;
              stateNext    = SWITCH;
            end
          end
        end
      end
      SWITCH: begin
        // Requests are ignored here; the next edge always returns to IDLE.
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      levelQ   <= '0;
      entryAck <= 1'b0;
      exitAck  <= 1'b0;
      stall    <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= stateNext;
      levelQ   <= levelNext;
      entryAck <= entryAckNext;
      exitAck  <= exitAckNext;
      stall    <= stallNext;
      error    <= errorNext;
    end
  end

  assign level = levelQ;

endmodule

// File: tb/tb_rf_level_ctrl.sv
module tb_rf_level_ctrl;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       entryReq;
  logic [2:0] entryLevel;
  logic       entryAck;
  logic       exitReq;
  logic       exitAck;
  logic [2:0] level;
  logic [2:0] depth;
  logic       empty;
  logic       full;
  logic       stall;
  logic       error;

  rf_level_ctrl #(.NumLevels(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .entryReq   (entryReq),
    .entryLevel (entryLevel),
    .entryAck   (entryAck),
    .exitReq    (exitReq),
    .exitAck    (exitAck),
    .level      (level),
    .depth      (depth),
    .empty      (empty),
    .full       (full),
    .stall      (stall),
    .error      (error)
  );

  always #5 clk = ~clk;

  int testsRun  = 0;
  int failCount = 0;

  // Reference model: stack of preempted levels plus the active level.
  int stack[$];
  int mLevel;
  bit mSwitch;
  bit mEntryAck, mExitAck, mStall, mError;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    chk({tag, ".level"},    32'(level),    32'(mLevel));
    chk({tag, ".depth"},    32'(depth),    32'(stack.size()));
    chk({tag, ".empty"},    32'(empty),    32'(stack.size() == 0));
    chk({tag, ".full"},     32'(full),     32'(stack.size() == N - 1));
    chk({tag, ".stall"},    32'(stall),    32'(mStall));
    chk({tag, ".entryAck"}, 32'(entryAck), 32'(mEntryAck));
    chk({tag, ".exitAck"},  32'(exitAck),  32'(mExitAck));
    chk({tag, ".error"},    32'(error),    32'(mError));
  endtask

  task automatic modelReset();
    stack.delete();
    mLevel    = 0;
    mSwitch   = 0;
    mEntryAck = 0;
    mExitAck  = 0;
    mStall    = 0;
    mError    = 0;
  endtask

  // Apply one cycle of the behavioural rules to the inputs sampled at an edge.
  task automatic modelEdge(input bit en, input int el, input bit ex);
    mEntryAck = 0;
    mExitAck  = 0;
    mStall    = 0;
    mError    = 0;
    if (mSwitch) begin
      mSwitch = 0;
    end else if (ex && en && stack.size() > 0 && el > stack[$]) begin
      mLevel = el;
      mEntryAck = 1; mExitAck = 1; mStall = 1; mSwitch = 1;
    end else if (ex && stack.size() > 0) begin
      mLevel = stack.pop_back();
      mExitAck = 1; mStall = 1; mSwitch = 1;
    end else begin
      if (ex) mError = 1;
      if (en && el > mLevel) begin
        if (stack.size() == N - 1) begin
          mError = 1;
        end else begin
          stack.push_back(mLevel);
          mLevel = el;
          mEntryAck = 1; mStall = 1; mSwitch = 1;
        end
      end
    end
  endtask

  task automatic step(input string tag, input bit en, input int el, input bit ex);
    entryReq   = en;
    entryLevel = 3'(el);
    exitReq    = ex;
    @(posedge clk);
    modelEdge(en, el, ex);
    #1;
    checkAll(tag);
  endtask

  bit         pend;
  logic [2:0] pl;
  bit         ex;

  initial begin
    reset      = 1'b0;
    entryReq   = 1'b0;
    entryLevel = '0;
    exitReq    = 1'b0;
    modelReset();

    // Reset held for two cycles, then released.
    repeat (2) @(posedge clk);
    #1;
    checkAll("inReset");
    reset = 1'b1;
    step("afterReset", 0, 0, 0);

    // Nested entries and an exit.
    step("enter3", 1, 3, 0);
    chk("enter3.levelConst", 32'(level), 32'd3);
    step("enter3.sw", 0, 0, 0);
    step("enter5", 1, 5, 0);
    chk("enter5.depthConst", 32'(depth), 32'd2);
    step("enter5.sw", 0, 0, 0);
    step("exit", 0, 0, 1);
    chk("exit.levelConst", 32'(level), 32'd3);
    step("exit.sw", 0, 0, 0);
    step("reenter5", 1, 5, 0);
    step("reenter5.sw", 0, 0, 0);

    // Lower-level request held while at level 5: never accepted.
    for (int i = 0; i < 4; i++) step("held2", 1, 2, 0);
    chk("held2.levelConst", 32'(level), 32'd5);
    step("held2.exitTo3", 1, 2, 1);
    step("held2.sw", 1, 2, 0);
    step("held2.tailTo2", 1, 2, 1);
    chk("held2.accepted", 32'(level), 32'd2);
    step("held2.sw2", 0, 0, 0);

    // Build stack=[0], level=3 and tail-chain to 4.
    step("toZero", 0, 0, 1);
    step("toZero.sw", 0, 0, 0);
    step("enter3b", 1, 3, 0);
    step("enter3b.sw", 0, 0, 0);
    step("tail4", 1, 4, 1);
    chk("tail4.levelConst", 32'(level), 32'd4);
    chk("tail4.bothAcks", 32'({entryAck, exitAck}), 32'd3);
    step("tail4.sw", 0, 0, 0);
    step("exitTo0", 0, 0, 1);
    step("exitTo0.sw", 0, 0, 0);

    // Exit while empty.
    step("emptyExit", 0, 0, 1);
    chk("emptyExit.errConst", 32'(error), 32'd1);
    step("emptyExit.after", 0, 0, 0);

    // Fill the stack, then reset during the final SWITCH.
    for (int i = 1; i <= 7; i++) begin
      step("fill", 1, i, 0);
      if (i < 7) step("fill.sw", 0, 0, 0);
    end
    chk("fill.fullConst", 32'(full), 32'd1);
    entryReq = 1'b0;
    #2;
    reset = 1'b0;
    modelReset();
    #1;
    checkAll("midSwitchReset");
    @(negedge clk);
    reset = 1'b1;
    step("postReset", 0, 0, 0);

    // Randomized traffic with a requester that holds until acknowledged.
    pend = 0;
    pl   = '0;
    for (int c = 0; c < 400; c++) begin
      if (!pend && $urandom_range(0, 2) == 0) begin
        pend = 1;
        pl   = 3'($urandom_range(0, 7));
      end
      ex = (!mSwitch && $urandom_range(0, 3) == 0);
      step("rand", pend, int'(pl), ex);
      if (mEntryAck) pend = 0;
      else if (pend && $urandom_range(0, 7) == 0) pend = 0;
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
